// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared FSM encoding and default sizing for the UART TX byte queue.
package uart_tx_fifo_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/uart_tx_fifo_regfile.sv
// fifo_regfile: unreset circular storage, synchronous write and combinational read by pointer.
module fifo_regfile #(
  parameter int DEPTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]    i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0]    o_rd_data
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: queues bus stores and launches them one at a time into the UART transmitter.
// Optional sticky overflow flag enabled by UART_TX_FIFO_OVF_EN.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     tx_done,
  output logic                     tx_start,
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     busy
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic                     overflow,
  input  logic                     clr_overflow
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_state, r_tx_start;
  logic [DATA_WIDTH-1:0] r_tx_data, w_rd_data;
  logic                  w_pop, w_push;
  // A push into a full queue still fits when the same edge pops an entry.
  assign w_pop  = (r_state == ST_IDLE) && (r_count != '0);
  assign w_push = wr_en && (!full || w_pop);
  assign count    = r_count;
  assign empty    = r_count == '0;
  assign full     = r_count == CW'(DEPTH);
  assign busy     = r_state;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  fifo_regfile #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_regfile (
    .clk      (clk),
    .i_wr_en  (w_push),
    .i_wr_addr(r_wptr),
    .i_wr_data(wr_data),
    .i_rd_addr(r_rptr),
    .o_rd_data(w_rd_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_state    <= ST_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_pop) r_tx_data <= w_rd_data;
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_tx_start <= w_pop;
      r_state    <= w_pop ? ST_BUSY : (tx_done ? ST_IDLE : r_state);
    end
`ifdef UART_TX_FIFO_OVF_EN
  logic r_overflow;
  assign overflow = r_overflow;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_overflow <= 1'b0;
    else r_overflow <= (wr_en && !w_push) ? 1'b1 : (clr_overflow ? 1'b0 : r_overflow);
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of queueing, launch timing, full/drop, wrap and async reset.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       tx_done = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] count;
  logic       empty, full, busy;
`ifdef UART_TX_FIFO_OVF_EN
  logic overflow;
  logic clr_overflow = 1'b0;
`endif
  int n_checks = 0;
  int n_fail = 0;

  uart_tx_fifo #(.DEPTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .tx_done(tx_done),
    .tx_start(tx_start), .tx_data(tx_data), .count(count), .empty(empty),
    .full(full), .busy(busy)
`ifdef UART_TX_FIFO_OVF_EN
    , .overflow(overflow), .clr_overflow(clr_overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 50 && !tx_start; i++) step();
    check(tag, tx_start, 1);
  endtask

  task automatic drain(input logic [7:0] exp, input string tag);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    wait_start({tag, "_start"});
    check({tag, "_data"}, tx_data, exp);
  endtask

  logic [7:0] got[$];
  int t;
  int idx;

  initial begin
    #12;
    check("rst_start", tx_start, 0);
    check("rst_data", tx_data, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
`ifdef UART_TX_FIFO_OVF_EN
    check("rst_ovf", overflow, 0);
`endif
    step();
    rst_n = 1'b1;
    step();

    // single byte: launch visible two edges after the push
    wr_en = 1'b1; wr_data = 8'h41;
    step();
    wr_en = 1'b0;
    check("one_cnt1", count, 1);
    check("one_nostart", tx_start, 0);
    step();
    check("one_start", tx_start, 1);
    check("one_data", tx_data, 8'h41);
    check("one_cnt0", count, 0);
    check("one_busy", busy, 1);
    step();
    check("one_pulse", tx_start, 0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("one_idle", busy, 0);
    step();
    check("one_quiet", tx_start, 0);

    // three-byte burst answered 10 cycles after each launch
    wr_en = 1'b1; wr_data = 8'h10;
    step();
    wr_data = 8'h11;
    step();
    check("burst_start0", tx_start, 1);
    check("burst_data0", tx_data, 8'h10);
    check("burst_cnt", count, 1);
    wr_data = 8'h12;
    step();
    wr_en = 1'b0;
    check("burst_cnt2", count, 2);
    for (int k = 1; k < 3; k++) begin
      repeat (10) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check("burst_gap", tx_start, 0);
      step();
      check("burst_start", tx_start, 1);
      check("burst_data", tx_data, 8'h10 + k);
    end
    repeat (10) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("burst_empty", empty, 1);
    check("burst_idle", busy, 0);

    // fill: one in flight plus 8 queued, 10th push dropped
    for (int k = 0; k < 9; k++) begin
      wr_en = 1'b1; wr_data = 8'h20 + k;
      step();
    end
    check("fill_full", full, 1);
    check("fill_cnt", count, 8);
    wr_data = 8'h29;
    step();
    wr_en = 1'b0;
    check("drop_cnt", count, 8);
    check("drop_full", full, 1);
`ifdef UART_TX_FIFO_OVF_EN
    check("ovf_set", overflow, 1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("ovf_clr", overflow, 0);
`endif
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    wr_en = 1'b1; wr_data = 8'h2A;
    step();
    wr_en = 1'b0;
    check("fullpop_cnt", count, 8);
    check("fullpop_start", tx_start, 1);
    check("fullpop_data", tx_data, 8'h21);
`ifdef UART_TX_FIFO_OVF_EN
    check("fullpop_noovf", overflow, 0);
`endif
    for (int k = 2; k < 9; k++) drain(8'h20 + k, "drain");
    drain(8'h2A, "drain_last");
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("drain_empty", empty, 1);

    // 20 bytes, 5-cycle turnaround, pointers wrap
    idx = 0; t = 0;
    for (int c = 0; c < 600 && got.size() < 20; c++) begin
      wr_en = (idx < 20) && !full;
      wr_data = 8'h60 + idx[7:0];
      if (wr_en) idx++;
      tx_done = 1'b0;
      if (tx_start) begin
        got.push_back(tx_data);
        t = 5;
      end else if (t > 0) begin
        t--;
        if (t == 0) tx_done = 1'b1;
      end
      step();
    end
    wr_en = 1'b0;
    tx_done = 1'b0;
    check("wrap_n", got.size(), 20);
    for (int k = 0; k < 20 && k < got.size(); k++) check("wrap_data", got[k], 8'h60 + k);
    repeat (8) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();

    // async reset while busy with three queued bytes
    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1; wr_data = 8'h70 + k;
      step();
    end
    wr_en = 1'b0;
    check("pre_rst_cnt", count, 3);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_data", tx_data, 8'h70);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cnt", count, 0);
    check("arst_busy", busy, 0);
    check("arst_data", tx_data, 0);
    check("arst_empty", empty, 1);
    check("arst_start", tx_start, 0);
    step();
    rst_n = 1'b1;
    step();
    wr_en = 1'b1; wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    step();
    check("post_start", tx_start, 1);
    check("post_data", tx_data, 8'h55);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer between the memory-mapped bus decoder and the UART transmitter. The core stores bytes to the UART TX address. This block queues those bytes and launches them one at a time into the transmitter, which handshakes with a completion pulse. It lets software burst-write up to DEPTH bytes without polling `finished_tx` between stores.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of two and at least 2.
- `DATA_WIDTH`, 8: byte width passed to the transmitter.

Ports:
- `clk`, input, 1: system clock. All state changes on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `wr_en`, input, 1: push strobe, driven by the decoder's UART write enable. One push per high cycle.
- `wr_data`, input, DATA_WIDTH: byte to push; low byte of the bus write data.
- `tx_done`, input, 1: single-cycle pulse from the transmitter after the stop bit completes.
- `tx_start`, output, 1: single-cycle launch pulse to the transmitter.
- `tx_data`, output, DATA_WIDTH: byte being transmitted; held stable from the `tx_start` cycle until the next launch.
- `count`, output, $clog2(DEPTH)+1: number of queued bytes, excluding the byte in flight.
- `empty`, output, 1: high when `count` is 0.
- `full`, output, 1: high when `count` equals DEPTH.
- `busy`, output, 1: high while the FSM is in BUSY.
- `overflow`, output, 1: sticky flag for a dropped push. Present only with the macro (see Configuration).
- `clr_overflow`, input, 1: clears `overflow`. Present only with the macro.

## Operation
- Reset values:
  - `tx_start` = 0, `tx_data` = 0, `count` = 0, `empty` = 1, `full` = 0, `busy` = 0, `overflow` = 0.
  - Pointers = 0, FSM = IDLE.
- Storage is circular. Write and read pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- Push:
  - When `wr_en` is high and the FIFO is not full, store `wr_data` at the write pointer, increment the write pointer, and increment `count`.
- Push while full:
  - If a pop occurs in the same cycle, the push is accepted and `count` is unchanged.
  - Otherwise the byte is dropped and the FIFO is unchanged.
- FSM states: IDLE and BUSY.
  - IDLE with `count` > 0:
    - Pop the entry at the read pointer into `tx_data` and increment the read pointer.
    - Pulse `tx_start` for one cycle and go to BUSY.
  - IDLE with `count` = 0: stay in IDLE. `tx_start` = 0.
  - BUSY:
    - `tx_start` = 0.
    - On `tx_done`, go to IDLE.
    - Pushes continue to be accepted.
- `tx_done` received in IDLE is ignored.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Push into an empty FIFO while IDLE: the byte is not launched in the same cycle. It launches on the following edge.

## Timing
- Push at edge N: `count` and `empty` update after edge N.
- When IDLE and the FIFO was empty, `tx_start` is high during the cycle after edge N+1. That is 2-edge latency from the sampled `wr_en` to a visible `tx_start`.
- `tx_done` sampled at edge M returns the FSM to IDLE. The next `tx_start` is high after edge M+1.
- Minimum gap between launches: 2 cycles beyond the transmitter's own duration.
- All outputs are registered except `empty` and `full`, which decode combinationally from `count`.
- `rst_n` asserted mid-transmission:
  - All state clears immediately and `tx_start` drops asynchronously.
  - Queued bytes are lost. The transmitter is reset by the same net.

## Configuration
- `UART_TX_FIFO_OVF_EN` defined:
  - `overflow` is set on any dropped push and stays set until `clr_overflow` is high at an edge.
  - If a drop and `clr_overflow` occur in the same cycle, set wins.
- `UART_TX_FIFO_OVF_EN` not defined:
  - `overflow` and `clr_overflow` ports are absent.
  - Dropped pushes are silent. No other behaviour changes.

## Structure
- Package `uart_tx_fifo_pkg`:
  - FSM state encoding localparams: `ST_IDLE` = 1'b0, `ST_BUSY` = 1'b1.
  - Default `DEPTH` and `DATA_WIDTH` constants.
- Sub-module `fifo_regfile`: DEPTH×DATA_WIDTH register array with synchronous write and combinational read by pointer. No reset on the data array.
- The top `uart_tx_fifo` holds the pointers, count, FSM, and overflow logic.

## Test plan
- Reset, then a single push of 0x41: `tx_start` is high exactly 2 edges after the push, `tx_data` = 0x41, `count` = 0, `busy` = 1. `tx_done` returns `busy` to 0.
- Push 0x10, 0x11, 0x12 on consecutive cycles, then answer each launch with `tx_done` 10 cycles later: launches occur in order 0x10, 0x11, 0x12, each 2 edges after the preceding `tx_done`, ending with `empty` = 1.
- Hold `tx_done` low and push 9 bytes with DEPTH = 8:
  - The first byte goes in flight and the next 8 fill the FIFO, so `full` = 1 and `count` = 8.
  - A 10th push is dropped, `count` stays 8, and with the macro `overflow` = 1.
  - `clr_overflow` clears it.
- With the FIFO full and the FSM in IDLE, push while a pop occurs: `count` stays 8 and the pushed byte emerges last.
- Push 20 bytes with a 5-cycle `tx_done` turnaround: pointers wrap and all 20 bytes emerge in order with no loss.
- Assert `rst_n` low while BUSY with 3 bytes queued: outputs return to their reset values immediately. A push after release is launched normally.
